// File: rtl/speaker_tone_arbiter.sv
// speaker_tone_arbiter: fixed-priority owner selection for the shared speaker
// tone generator, with a minimum-hold window and a silent gap between owners.
// Optional build macro SPK_ARB_PREEMPT_EN: lets a higher-priority requester
// take over once the current owner has held the grant for MIN_HOLD cycles.
module speaker_tone_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned HP_W       = 32,
    parameter int unsigned MIN_HOLD   = 2_500_000,
    parameter int unsigned GAP_CYCLES = 25_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*HP_W-1:0]   req_half_period,
    output logic [NUM_REQ-1:0]        grant,
    output logic [1:0]                owner_id,
    output logic                      tone_en,
    output logic [HP_W-1:0]           tone_half_period,
    output logic                      busy,
    output logic                      preempt_pulse
);

    localparam int unsigned ID_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_d;
    logic [ID_W-1:0]     owner_d;
    logic                tone_en_d;
    logic [HP_W-1:0]     thp_d;
    logic                busy_d;
    logic                pp_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [ID_W-1:0]     win;
    logic                leave;
    logic [HP_W-1:0]     hp_arr [NUM_REQ];

    // Unpack the flat half-period bus into one entry per source
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hp
        assign hp_arr[g] = req_half_period[g*HP_W +: HP_W];
    end

    // Fixed-priority encoder: lowest set index wins
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win = ID_W'(i);
        end
    end

`ifdef SPK_ARB_PREEMPT_EN
    logic higher_req;

    // Any requester with priority above the current owner
    always_comb begin
        higher_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (ID_W'(i) < owner_id)) higher_req = 1'b1;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        owner_d   = '0;
        tone_en_d = 1'b0;
        thp_d     = '0;
        busy_d    = 1'b0;
        pp_d      = 1'b0;
        hold_d    = hold_q;
        gap_d     = gap_q;
        leave     = 1'b0;

        case (state_q)
            IDLE: begin
                hold_d = '0;
                gap_d  = '0;
                if (|req) begin
                    state_d = PLAY;
                    grant_d = NUM_REQ'(1) << win;
                    owner_d = win;
                    thp_d   = hp_arr[win];
                    busy_d  = 1'b1;
                    hold_d  = CNT_W'(1);
                end
            end

            PLAY: begin
                // A dropped request is always a release, even if a
                // higher-priority request rises in the same cycle.
                if (!req[owner_id]) begin
                    leave = 1'b1;
`ifdef SPK_ARB_PREEMPT_EN
                end else if ((hold_q == CNT_W'(MIN_HOLD)) && higher_req) begin
                    leave = 1'b1;
                    pp_d  = 1'b1;
`endif
                end else begin
                    grant_d   = grant;
                    owner_d   = owner_id;
                    thp_d     = hp_arr[owner_id];
                    tone_en_d = (tone_half_period >= HP_W'(2));
                    busy_d    = 1'b1;
                    if (hold_q < CNT_W'(MIN_HOLD)) hold_d = hold_q + CNT_W'(1);
                end

                if (leave) begin
                    hold_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        busy_d  = 1'b1;
                        gap_d   = CNT_W'(1);
                    end
                end
            end

            GAP: begin
                if (gap_q >= CNT_W'(GAP_CYCLES)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    busy_d = 1'b1;
                    gap_d  = gap_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            grant            <= '0;
            owner_id         <= '0;
            tone_en          <= 1'b0;
            tone_half_period <= '0;
            busy             <= 1'b0;
            preempt_pulse    <= 1'b0;
            hold_q           <= '0;
            gap_q            <= '0;
        end else begin
            state_q          <= state_d;
            grant            <= grant_d;
            owner_id         <= owner_d;
            tone_en          <= tone_en_d;
            tone_half_period <= thp_d;
            busy             <= busy_d;
            preempt_pulse    <= pp_d;
            hold_q           <= hold_d;
            gap_q            <= gap_d;
        end
    end

endmodule
